// File: rtl/bsg_axil_s_iic_regs_to_link.sv
// bsg_axil_s_iic_regs_to_link: AXI-Lite IIC register subset (CR/SR/TX_FIFO/RX_FIFO/PIRQ) bridged to a bsg ready_and link
module bsg_axil_s_iic_regs_to_link #(
  parameter int addr_width_p = 9,
  parameter int data_width_p = 32,
  parameter int link_data_width_p = 8,
  parameter int fifo_els_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [addr_width_p-1:0] awaddr_i,
  input  logic awvalid_i,
  output logic awready_o,
  input  logic [data_width_p-1:0] wdata_i,
  input  logic [data_width_p/8-1:0] wstrb_i,
  input  logic wvalid_i,
  output logic wready_o,
  output logic [1:0] bresp_o,
  output logic bvalid_o,
  input  logic bready_i,
  input  logic [addr_width_p-1:0] araddr_i,
  input  logic arvalid_i,
  output logic arready_o,
  output logic [data_width_p-1:0] rdata_o,
  output logic [1:0] rresp_o,
  output logic rvalid_o,
  input  logic rready_i,
  input  logic [link_data_width_p+1:0] link_i,
  output logic [link_data_width_p+1:0] link_o
);
  localparam int lg_lp = $clog2(fifo_els_p);
  localparam logic [lg_lp:0] els_lp = (lg_lp+1)'(fifo_els_p);
  localparam logic [8:0] cr_a = 9'h100, sr_a = 9'h104, tx_a = 9'h108, rx_a = 9'h10C, pirq_a = 9'h120;
  logic [1:0] cr;
  logic [3:0] pirq;
  logic [link_data_width_p-1:0] tx_mem [fifo_els_p];
  logic [link_data_width_p-1:0] rx_mem [fifo_els_p];
  logic [lg_lp:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [8:0] wa, ra;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_v, rx_rdy;
  logic w_acc, we, w_mapped, r_mapped, ar_acc, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] sr;
  logic [data_width_p-1:0] r_data_n;
  logic [1:0] r_resp_n;
  logic unused;
  assign unused = ^{awaddr_i, araddr_i, wdata_i, wstrb_i};
  assign wa = awaddr_i[8:0];
  assign ra = araddr_i[8:0];
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full = (tx_wp - tx_rp) == els_lp;
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full = (rx_wp - rx_rp) == els_lp;
  assign tx_v = reset_n_i & cr[0] & ~cr[1] & ~tx_empty;
  assign rx_rdy = reset_n_i & cr[0] & ~rx_full;
  assign link_o = {tx_v, rx_rdy, tx_mem[tx_rp[lg_lp-1:0]]};
  assign tx_pop = tx_v & link_i[link_data_width_p];
  assign rx_push = link_i[link_data_width_p+1] & rx_rdy;
  assign sr = {tx_empty, rx_empty, rx_full, tx_full, 1'b0, ~tx_empty | tx_v, 2'b00};
  assign w_mapped = wa inside {cr_a, sr_a, tx_a, rx_a, pirq_a};
  assign r_mapped = ra inside {cr_a, sr_a, tx_a, rx_a, pirq_a};
  assign w_acc = reset_n_i & ~bvalid_o & awvalid_i & wvalid_i & ~(wa == tx_a & tx_full & wstrb_i[0]);
  assign awready_o = w_acc;
  assign wready_o = w_acc;
  assign we = w_acc & wstrb_i[0];
  assign tx_push = we & (wa == tx_a) & ~cr[1];
  assign arready_o = reset_n_i & ~rvalid_o;
  assign ar_acc = arready_o & arvalid_i;
  assign rx_pop = ar_acc & (ra == rx_a) & ~rx_empty;
  always_comb begin
    r_data_n = ra == cr_a ? data_width_p'(cr)
             : ra == sr_a ? data_width_p'(sr)
             : ra == pirq_a ? data_width_p'(pirq)
             : (ra == rx_a & ~rx_empty) ? data_width_p'(rx_mem[rx_rp[lg_lp-1:0]])
             : '0;
    r_resp_n = (ra == rx_a & rx_empty) ? 2'b10 : r_mapped ? 2'b00 : 2'b11;
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp[lg_lp-1:0]] <= wdata_i[link_data_width_p-1:0];
    if (rx_push) rx_mem[rx_wp[lg_lp-1:0]] <= link_i[link_data_width_p-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (~reset_n_i) begin
      cr <= '0;
      pirq <= '0;
      bvalid_o <= 1'b0;
      bresp_o <= '0;
      rvalid_o <= 1'b0;
      rdata_o <= '0;
      rresp_o <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (w_acc) begin
        bvalid_o <= 1'b1;
        bresp_o <= w_mapped ? 2'b00 : 2'b11;
      end else if (bready_i) bvalid_o <= 1'b0;
      if (we & wa == cr_a) cr <= wdata_i[1:0];
      if (we & wa == pirq_a) pirq <= wdata_i[3:0];
      if (ar_acc) begin
        rvalid_o <= 1'b1;
        rdata_o <= r_data_n;
        rresp_o <= r_resp_n;
      end else if (rready_i) rvalid_o <= 1'b0;
      if (cr[1]) begin
        tx_wp <= '0;
        tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop) tx_rp <= tx_rp + 1'b1;
      end
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_bsg_axil_s_iic_regs_to_link.sv
// tb_bsg_axil_s_iic_regs_to_link: directed scoreboard bench for the AXI-Lite IIC register link bridge
module tb_bsg_axil_s_iic_regs_to_link;
  localparam logic [8:0] CR = 9'h100, SR = 9'h104, TX = 9'h108, RX = 9'h10C, PIRQ = 9'h120, BAD = 9'h1F0;
  logic clk = 0;
  logic reset_n;
  logic [8:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [1:0] bresp_o, rresp_o;
  logic [31:0] rdata_o;
  logic li_v, li_rdy;
  logic [7:0] li_data;
  logic [9:0] link_o;
  int n = 0, fails = 0;
  logic [1:0] bq [$];
  logic [34:0] rq [$];
  logic [7:0] txq [$];
  always #5 clk = ~clk;
  bsg_axil_s_iic_regs_to_link dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_o),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .link_i({li_v, li_rdy, li_data}), .link_o(link_o)
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  always @(negedge clk) if (reset_n === 1'b1 && link_o[9] && li_rdy) begin
    chk("tx_avail", 64'(txq.size() != 0), 1);
    if (txq.size() != 0) chk("tx_data", link_o[7:0], txq.pop_front());
  end
  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r, input int hold);
    int t;
    logic [1:0] e;
    bq.push_back(r);
    bready = (hold == 0);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready_o && t < 100);
    chk("awready", {awready_o, wready_o}, 2'b11);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    e = bq.pop_front();
    @(negedge clk); chk("bresp", {bvalid_o, bresp_o}, {1'b1, e});
    for (int i = 0; i < hold; i++) begin @(negedge clk); chk("bhold", {bvalid_o, bresp_o}, {1'b1, e}); end
    if (hold > 0) begin @(posedge clk); #1 bready = 1; end
    @(posedge clk); #1 chk("bclr", bvalid_o, 0);
  endtask
  task automatic rd(input logic [8:0] a, input logic [31:0] d, input logic [1:0] r, input int hold);
    int t;
    logic [34:0] e;
    rq.push_back({1'b1, r, d});
    rready = (hold == 0);
    araddr = a; arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready_o && t < 100);
    chk("arready", arready_o, 1);
    @(posedge clk); #1 arvalid = 0;
    e = rq.pop_front();
    @(negedge clk); chk("rdata", {rvalid_o, rresp_o, rdata_o}, e);
    for (int i = 0; i < hold; i++) begin @(negedge clk); chk("rhold", {rvalid_o, rresp_o, rdata_o}, e); end
    if (hold > 0) begin @(posedge clk); #1 rready = 1; end
    @(posedge clk); #1 chk("rclr", rvalid_o, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 0; awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    awaddr = CR; araddr = SR; wdata = 0; wstrb = 4'hF;
    li_v = 0; li_rdy = 0; li_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {awready_o, wready_o, arready_o}, 0);
    chk("rst_valid", {bvalid_o, rvalid_o}, 0);
    chk("rst_data", {rdata_o, bresp_o, rresp_o}, 0);
    chk("rst_link", link_o[9:8], 0);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0; reset_n = 1;
    wr(CR, 32'h2, 4'h1, 2'b00, 0);
    wr(CR, 32'h2, 4'h1, 2'b00, 0);
    wr(CR, 32'h1, 4'h1, 2'b00, 0);
    wr(PIRQ, 32'hF, 4'h1, 2'b00, 0);
    rd(SR, 32'hC0, 2'b00, 0);
    rd(PIRQ, 32'hF, 2'b00, 0);
    rd(CR, 32'h1, 2'b00, 0);
    chk("link_v_idle", link_o[9], 0);
    li_rdy = 1;
    txq.push_back(8'hA5); wr(TX, 32'h1A5, 4'h1, 2'b00, 0);
    txq.push_back(8'h03); wr(TX, 32'h03, 4'h1, 2'b00, 0);
    txq.push_back(8'h7F); wr(TX, 32'h7F, 4'h1, 2'b00, 0);
    repeat (4) @(posedge clk);
    #1 chk("txq_drain1", txq.size(), 0);
    rd(SR, 32'hC0, 2'b00, 0);
    li_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      txq.push_back(8'(i * 7 + 1));
      wr(TX, 32'(i * 7 + 1), 4'h1, 2'b00, 0);
    end
    rd(SR, 32'h54, 2'b00, 0);
    awaddr = TX; wdata = 32'h99; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 1;
    repeat (3) begin @(negedge clk); chk("stall_full", awready_o, 0); end
    @(posedge clk); #1 li_rdy = 1;
    @(negedge clk); chk("stall_popcyc", awready_o, 0);
    @(posedge clk); #1 li_rdy = 0;
    @(negedge clk); chk("unstall", {awready_o, wready_o}, 2'b11);
    txq.push_back(8'h99); bq.push_back(2'b00);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk); chk("bresp17", {bvalid_o, bresp_o}, {1'b1, bq.pop_front()});
    @(posedge clk); #1 li_rdy = 1;
    repeat (20) @(posedge clk);
    #1 chk("txq_drain2", txq.size(), 0);
    rd(SR, 32'hC0, 2'b00, 0);
    li_v = 1; li_data = 8'h66;
    @(posedge clk); #1 li_data = 8'h12;
    @(posedge clk); #1 li_v = 0; li_data = 8'h00;
    rd(SR, 32'h80, 2'b00, 0);
    rd(RX, 32'h66, 2'b00, 0);
    rd(RX, 32'h12, 2'b00, 0);
    rd(RX, 32'h0, 2'b10, 0);
    rd(SR, 32'hC0, 2'b00, 0);
    wr(PIRQ, 32'h5, 4'h1, 2'b00, 5);
    rd(PIRQ, 32'h5, 2'b00, 5);
    wr(BAD, 32'h1, 4'h1, 2'b11, 0);
    rd(BAD, 32'h0, 2'b11, 0);
    wr(SR, 32'hFF, 4'h1, 2'b00, 0);
    rd(TX, 32'h0, 2'b00, 0);
    wr(TX, 32'h55, 4'h0, 2'b00, 0);
    repeat (3) @(posedge clk);
    #1 chk("wstrb0_nopush", link_o[9], 0);
    rd(SR, 32'hC0, 2'b00, 0);
    li_rdy = 0;
    txq.push_back(8'h11); wr(TX, 32'h11, 4'h1, 2'b00, 0);
    txq.push_back(8'h22); wr(TX, 32'h22, 4'h1, 2'b00, 0);
    txq.push_back(8'h33); wr(TX, 32'h33, 4'h1, 2'b00, 0);
    awaddr = TX; wdata = 32'h44; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 0;
    txq.push_back(8'h44);
    @(negedge clk); chk("aw4", awready_o, 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk); chk("wresp_before_rst", bvalid_o, 1);
    reset_n = 0;
    @(posedge clk); #1 chk("rst_bvalid", bvalid_o, 0);
    chk("rst_link_v", link_o[9], 0);
    reset_n = 1; bready = 1; txq.delete();
    rd(SR, 32'hC0, 2'b00, 0);
    li_rdy = 1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_link_v", link_o[9], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
